// File: rtl/lease_table_loader_pkg.sv
// -----------------------------------------------------------------------------
// lease_table_loader_pkg
//
// Shared definitions for the lease-table image loader:
//   - lease table indices (the {table, entry} address carries one of these in
//     its top two bits)
//   - header word offsets inside a lease-table image
//   - FSM state encoding and the "which word are we on" encoding
// -----------------------------------------------------------------------------
package lease_table_loader_pkg;

    // Lease table selectors, in the order they are laid out in the image.
    localparam int               TBL_W      = 2;
    localparam logic [TBL_W-1:0] TBL_ADDR   = 2'd0;  // reference address
    localparam logic [TBL_W-1:0] TBL_LEASE0 = 2'd1;  // lease0
    localparam logic [TBL_W-1:0] TBL_LEASE1 = 2'd2;  // lease1
    localparam logic [TBL_W-1:0] TBL_PROB   = 2'd3;  // lease0 probability

    // Header layout relative to the image base.
    localparam int HDR_DEFAULT = 0;  // default lease word
    localparam int HDR_COUNT   = 1;  // entry count word, count in [15:0]
    localparam int HDR_WORDS   = 2;  // first table starts after the header

    localparam int COUNT_W = 16;
    localparam int DATA_W  = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REQ    = 2'd1,
        ST_WRITE  = 2'd2,
        ST_FINISH = 2'd3
    } state_t;

    // Which image word the current REQ/WRITE pair is handling.
    typedef enum logic [1:0] {
        WORD_HDR0  = 2'd0,
        WORD_HDR1  = 2'd1,
        WORD_ENTRY = 2'd2
    } word_t;

endpackage

// File: rtl/lease_table_loader.sv
// -----------------------------------------------------------------------------
// lease_table_loader
//
// Fetches a lease-table image from word-addressed memory over a
// single-outstanding req/ack port and replays it as configuration writes for
// the lease cache policy controller.
//
// Image layout at base B:
//   B+0              default lease        -> con_wren_o
//   B+1              count N_img in [15:0]
//   B+2+t*N_img+i    table t, entry i     -> llt_wren_o at {t, i}
// Only the first min(N_img, LLT_ENTRIES) entries of each table are fetched;
// the table stride in memory is always N_img.
//
// Ports:
//   clock_i, reset_i      clock, synchronous active-high reset
//   start_i, base_addr_i  start pulse and image base (sampled in IDLE only)
//   mem_req_o/mem_addr_o  read request, held with a stable address until ack
//   mem_ack_i/mem_data_i  read completion, data valid in the ack cycle
//   con_wren_o            default-lease register write strobe
//   llt_wren_o            lease-table write strobe
//   llt_addr_o            {table[1:0], entry}, 0 when no table write
//   llt_data_o            write data, 0 when no strobe
//   busy_o                load in progress (REQ/WRITE)
//   done_o                one-cycle completion pulse
//   error_o               sticky: image count exceeded LLT_ENTRIES
// -----------------------------------------------------------------------------
module lease_table_loader
    import lease_table_loader_pkg::*;
#(
    parameter int LLT_ENTRIES = 128,
    parameter int BW_ENTRIES  = $clog2(LLT_ENTRIES),
    parameter int BW_MEM_ADDR = 24
) (
    input  logic                   clock_i,
    input  logic                   reset_i,
    input  logic                   start_i,
    input  logic [BW_MEM_ADDR-1:0] base_addr_i,
    output logic                   mem_req_o,
    output logic [BW_MEM_ADDR-1:0] mem_addr_o,
    input  logic                   mem_ack_i,
    input  logic [DATA_W-1:0]      mem_data_i,
    output logic                   con_wren_o,
    output logic                   llt_wren_o,
    output logic [BW_ENTRIES+1:0]  llt_addr_o,
    output logic [DATA_W-1:0]      llt_data_o,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   error_o
);

    // The effective count can equal LLT_ENTRIES, so it needs one bit more
    // than an entry index.
    localparam int NEFF_W = BW_ENTRIES + 1;

    localparam logic [BW_MEM_ADDR-1:0] ADDR_ONE = BW_MEM_ADDR'(1);
    localparam logic [BW_ENTRIES-1:0]  IDX_ONE  = BW_ENTRIES'(1);
    localparam logic [NEFF_W-1:0]      NEFF_ONE = NEFF_W'(1);
    localparam logic [NEFF_W-1:0]      NEFF_CAP = NEFF_W'(LLT_ENTRIES);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_t                 state_q;
    state_t                 state_d;
    word_t                  word_q;
    logic [BW_MEM_ADDR-1:0] base_q;       // image base B
    logic [BW_MEM_ADDR-1:0] addr_q;       // address of the word being fetched
    logic [BW_MEM_ADDR-1:0] tbl_base_q;   // first word of the current table
    logic [COUNT_W-1:0]     n_img_q;      // count from the image (table stride)
    logic [NEFF_W-1:0]      n_eff_q;      // entries actually loaded per table
    logic [TBL_W-1:0]       tbl_q;
    logic [BW_ENTRIES-1:0]  idx_q;
    logic [DATA_W-1:0]      data_q;       // word captured on mem_ack_i
    logic                   err_q;

    // -------------------------------------------------------------------------
    // Derived values
    // -------------------------------------------------------------------------
    logic [COUNT_W-1:0]     count_w;
    logic                   count_over;
    logic [NEFF_W-1:0]      n_eff_d;
    logic                   last_entry;
    logic [BW_MEM_ADDR-1:0] next_tbl_base;

    // Count comes from the low half of the HDR1 word only.
    assign count_w       = data_q[COUNT_W-1:0];
    assign count_over    = 32'(count_w) > 32'(LLT_ENTRIES);
    assign n_eff_d       = count_over ? NEFF_CAP : NEFF_W'(count_w);
    // n_eff_q >= 1 whenever entries are being written, so no underflow here.
    assign last_entry    = ({1'b0, idx_q} == (n_eff_q - NEFF_ONE));
    // Tables are strided by the image count even when clamped, so entries
    // beyond LLT_ENTRIES are skipped without being fetched.
    assign next_tbl_base = tbl_base_q + BW_MEM_ADDR'(n_img_q);

    // -------------------------------------------------------------------------
    // FSM state register
    // -------------------------------------------------------------------------
    // NOTE: every clocked assignment is non-blocking so all registers update
    // from the same pre-edge values, independent of statement order.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // FSM next state and outputs
    // -------------------------------------------------------------------------
    // NOTE: each signal written here gets a default first; a path that left
    // one unassigned would infer a latch.
    always_comb begin
        state_d    = state_q;
        mem_req_o  = 1'b0;
        mem_addr_o = '0;
        con_wren_o = 1'b0;
        llt_wren_o = 1'b0;
        llt_addr_o = '0;
        llt_data_o = '0;
        busy_o     = 1'b0;
        done_o     = 1'b0;
        error_o    = err_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_REQ;
                end
            end

            ST_REQ: begin
                busy_o     = 1'b1;
                mem_req_o  = 1'b1;
                mem_addr_o = addr_q;
                if (mem_ack_i) begin
                    state_d = ST_WRITE;
                end
            end

            ST_WRITE: begin
                busy_o = 1'b1;
                unique case (word_q)
                    WORD_HDR0: begin
                        con_wren_o = 1'b1;
                        llt_data_o = data_q;
                        state_d    = ST_REQ;
                    end
                    WORD_HDR1: begin
                        state_d = (n_eff_d == '0) ? ST_FINISH : ST_REQ;
                    end
                    WORD_ENTRY: begin
                        llt_wren_o = 1'b1;
                        llt_addr_o = {tbl_q, idx_q};
                        llt_data_o = data_q;
                        if (last_entry && (tbl_q == TBL_PROB)) begin
                            state_d = ST_FINISH;
                        end else begin
                            state_d = ST_REQ;
                        end
                    end
                    default: begin
                        state_d = ST_IDLE;
                    end
                endcase
            end

            ST_FINISH: begin
                done_o  = 1'b1;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath: addressing, counters, captured data, sticky error
    // -------------------------------------------------------------------------
    // NOTE: the captured data word is reset along with the control registers;
    // it is a single register, and a clean value keeps post-reset debug simple.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            word_q     <= WORD_HDR0;
            base_q     <= '0;
            addr_q     <= '0;
            tbl_base_q <= '0;
            n_img_q    <= '0;
            n_eff_q    <= '0;
            tbl_q      <= TBL_ADDR;
            idx_q      <= '0;
            data_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        base_q <= base_addr_i;
                        addr_q <= base_addr_i + BW_MEM_ADDR'(HDR_DEFAULT);
                        word_q <= WORD_HDR0;
                        tbl_q  <= TBL_ADDR;
                        idx_q  <= '0;
                        err_q  <= 1'b0;
                    end
                end

                ST_REQ: begin
                    if (mem_ack_i) begin
                        data_q <= mem_data_i;
                    end
                end

                ST_WRITE: begin
                    unique case (word_q)
                        WORD_HDR0: begin
                            word_q <= WORD_HDR1;
                            addr_q <= base_q + BW_MEM_ADDR'(HDR_COUNT);
                        end
                        WORD_HDR1: begin
                            word_q     <= WORD_ENTRY;
                            n_img_q    <= count_w;
                            n_eff_q    <= n_eff_d;
                            tbl_base_q <= base_q + BW_MEM_ADDR'(HDR_WORDS);
                            addr_q     <= base_q + BW_MEM_ADDR'(HDR_WORDS);
                            tbl_q      <= TBL_ADDR;
                            idx_q      <= '0;
                            if (count_over) begin
                                err_q <= 1'b1;
                            end
                        end
                        WORD_ENTRY: begin
                            if (last_entry) begin
                                tbl_base_q <= next_tbl_base;
                                addr_q     <= next_tbl_base;
                                tbl_q      <= tbl_q + 2'd1;
                                idx_q      <= '0;
                            end else begin
                                idx_q  <= idx_q + IDX_ONE;
                                addr_q <= addr_q + ADDR_ONE;
                            end
                        end
                        default: begin
                            word_q <= WORD_HDR0;
                        end
                    endcase
                end

                default: begin
                    // ST_FINISH: nothing to update; error_o stays sticky.
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lease_table_loader.sv
// -----------------------------------------------------------------------------
// tb_lease_table_loader
//
// Drives lease_table_loader (LLT_ENTRIES=4) against a memory responder with
// configurable random wait states. Expected write/fetch sequences come from a
// reference model that walks the image layout directly.
// -----------------------------------------------------------------------------
module tb_lease_table_loader;

    localparam int ENT = 4;
    localparam int BWE = $clog2(ENT);
    localparam int AW  = 24;
    localparam int LW  = BWE + 2;

    logic          clock = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] base_addr;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic          mem_ack;
    logic [31:0]   mem_data;
    logic          con_wren;
    logic          llt_wren;
    logic [LW-1:0] llt_addr;
    logic [31:0]   llt_data;
    logic          busy;
    logic          done;
    logic          error;

    always #5 clock = ~clock;

    lease_table_loader #(
        .LLT_ENTRIES (ENT),
        .BW_MEM_ADDR (AW)
    ) dut (
        .clock_i     (clock),
        .reset_i     (reset),
        .start_i     (start),
        .base_addr_i (base_addr),
        .mem_req_o   (mem_req),
        .mem_addr_o  (mem_addr),
        .mem_ack_i   (mem_ack),
        .mem_data_i  (mem_data),
        .con_wren_o  (con_wren),
        .llt_wren_o  (llt_wren),
        .llt_addr_o  (llt_addr),
        .llt_data_o  (llt_data),
        .busy_o      (busy),
        .done_o      (done),
        .error_o     (error)
    );

    // ------------------------------------------------------------------ check
    int tests_run    = 0;
    int tests_failed = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------ memory model
    logic [AW-1:0] cur_base  = '0;
    logic [31:0]   cur_count = '0;
    logic [31:0]   mem_seed  = 32'h1357_9BDF;

    // Image memory: count word at B+1, pseudo-random content elsewhere.
    function automatic logic [31:0] mem_view(input logic [AW-1:0] a);
        if (a == AW'(32'(cur_base) + 32'd1)) return cur_count;
        return (32'(a) * 32'h9E37_79B1) ^ mem_seed;
    endfunction

    int            max_wait     = 0;
    int            total_wait   = 0;
    int            unstable_cnt = 0;
    logic          hold_en      = 1'b0;
    logic [AW-1:0] hold_addr    = '0;
    logic          force_ack    = 1'b0;
    logic [AW-1:0] fetch_log[$];

    // Responder: acks each request after 0..max_wait extra cycles.
    initial begin : responder
        logic          pending;
        int            wait_left;
        logic [AW-1:0] req_addr;
        pending   = 1'b0;
        wait_left = 0;
        req_addr  = '0;
        mem_ack   = 1'b0;
        mem_data  = '0;
        forever begin
            @(negedge clock);
            mem_ack  = 1'b0;
            mem_data = '0;
            if (force_ack) begin
                mem_ack  = 1'b1;
                mem_data = 32'hDEAD_BEEF;
            end else if (!mem_req) begin
                pending = 1'b0;
            end else begin
                if (!pending) begin
                    pending    = 1'b1;
                    req_addr   = mem_addr;
                    wait_left  = $urandom_range(0, max_wait);
                    total_wait += wait_left;
                end else if (mem_addr !== req_addr) begin
                    unstable_cnt++;
                end
                if (hold_en && (mem_addr == hold_addr)) begin
                    // stall this request indefinitely
                end else if (wait_left == 0) begin
                    mem_ack  = 1'b1;
                    mem_data = mem_view(mem_addr);
                    fetch_log.push_back(mem_addr);
                    pending  = 1'b0;
                end else begin
                    wait_left--;
                end
            end
        end
    end

    // ------------------------------------------------------------------ monitor
    typedef struct packed {
        logic          is_con;
        logic [LW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    wr_t wr_log[$];
    int  overlap_cnt = 0;
    int  cyc         = 0;

    always @(posedge clock) cyc <= cyc + 1;

    initial begin : monitor
        forever begin
            @(negedge clock);
            if (con_wren || llt_wren) begin
                wr_log.push_back('{is_con: con_wren, addr: llt_addr, data: llt_data});
            end
            if ((con_wren && llt_wren) || ((con_wren || llt_wren) && mem_req)) begin
                overlap_cnt++;
            end
        end
    end

    // --------------------------------------------------------- reference model
    wr_t           exp_wr[$];
    logic [AW-1:0] exp_fetch[$];
    int            exp_neff;
    int            exp_err_m;

    function automatic void build_model(input logic [AW-1:0] b, input logic [31:0] cw);
        int            n_img;
        logic [AW-1:0] a;
        n_img = int'(cw[15:0]);
        exp_neff  = (n_img > ENT) ? ENT : n_img;
        exp_err_m = (n_img > ENT) ? 1 : 0;
        exp_wr.delete();
        exp_fetch.delete();
        exp_fetch.push_back(b);
        exp_wr.push_back('{is_con: 1'b1, addr: '0, data: mem_view(b)});
        exp_fetch.push_back(AW'(32'(b) + 32'd1));
        for (int t = 0; t < 4; t++) begin
            for (int i = 0; i < exp_neff; i++) begin
                a = AW'(32'(b) + 32'(2 + t * n_img + i));
                exp_fetch.push_back(a);
                exp_wr.push_back('{is_con: 1'b0, addr: {2'(t), BWE'(i)}, data: mem_view(a)});
            end
        end
    endfunction

    // --------------------------------------------------------------- one load
    // exp_* < 0 means "take the value from the reference model".
    task automatic run_load(input string tag, input logic [AW-1:0] b, input logic [31:0] cw,
                            input int mw, input int poke, input int exp_nwr,
                            input int exp_lat0, input int exp_err);
        int nwr_e;
        int lat_e;
        int err_e;
        int start_cyc;
        int k;
        cur_base  = b;
        cur_count = cw;
        max_wait  = mw;
        build_model(b, cw);
        nwr_e = (exp_nwr  < 0) ? exp_wr.size() : exp_nwr;
        lat_e = (exp_lat0 < 0) ? 2 * (2 + 4 * exp_neff) + 1 : exp_lat0;
        err_e = (exp_err  < 0) ? exp_err_m : exp_err;
        wr_log.delete();
        fetch_log.delete();
        total_wait   = 0;
        unstable_cnt = 0;
        overlap_cnt  = 0;

        @(negedge clock);
        start     = 1'b1;
        base_addr = b;
        start_cyc = cyc;
        @(negedge clock);
        start     = 1'b0;
        base_addr = AW'($urandom);
        check($sformatf("%s busy after start", tag), busy, 1'b1);
        check($sformatf("%s error cleared on start", tag), error, 1'b0);

        k = 0;
        while (k < 3000) begin
            start = (k == poke);
            if (k == poke) base_addr = b ^ 24'h5A5A5A;
            @(negedge clock);
            if (done) break;
            k++;
        end
        start = 1'b0;
        check($sformatf("%s done reached", tag), done, 1'b1);
        check($sformatf("%s latency", tag), cyc - start_cyc, lat_e + total_wait);
        check($sformatf("%s error at done", tag), error, err_e[0]);
        check($sformatf("%s busy at done", tag), busy, 1'b0);
        check($sformatf("%s write count", tag), wr_log.size(), nwr_e);
        for (int j = 0; j < exp_wr.size(); j++) begin
            check($sformatf("%s write %0d", tag, j),
                  (j < wr_log.size()) ? wr_log[j] : '0, exp_wr[j]);
        end
        check($sformatf("%s fetch count", tag), fetch_log.size(), exp_fetch.size());
        for (int j = 0; j < exp_fetch.size(); j++) begin
            check($sformatf("%s fetch %0d", tag, j),
                  (j < fetch_log.size()) ? fetch_log[j] : '0, exp_fetch[j]);
        end
        check($sformatf("%s addr stable", tag), unstable_cnt, 0);
        check($sformatf("%s strobe overlap", tag), overlap_cnt, 0);

        // start_i coinciding with done_o must be ignored.
        start     = 1'b1;
        base_addr = ~b;
        @(negedge clock);
        start = 1'b0;
        check($sformatf("%s start on done ignored", tag), {busy, mem_req, done}, 3'b000);
        check($sformatf("%s error sticky", tag), error, err_e[0]);
    endtask

    // ---------------------------------------------------------------- vectors
    typedef struct {
        logic [AW-1:0] base;
        logic [31:0]   cw;
        int            mw;
        int            poke;
        int            nwr;
        int            lat;
        int            err;
    } vec_t;

    vec_t vecs[8];

    initial begin : watchdog
        #5ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int k;
        vecs[0] = '{24'h000100, 32'd2,          0, -1,  9, 21, 0};
        vecs[1] = '{24'h000200, 32'd0,          0, -1,  1,  5, 0};
        vecs[2] = '{24'h000300, 32'd6,          0, -1, 17, 37, 1};
        vecs[3] = '{24'h000400, 32'd4,          0, -1, 17, 37, 0};
        vecs[4] = '{24'h000500, 32'hABCD_0001,  0, -1,  5, 13, 0};
        vecs[5] = '{24'hFFFFFE, 32'd3,          0, -1, 13, 29, 0};
        vecs[6] = '{24'hFFFF00, 32'h0000_FFFF,  3, -1, 17, 37, 1};
        vecs[7] = '{24'h000100, 32'd2,          4,  7,  9, 21, 0};

        reset     = 1'b1;
        start     = 1'b0;
        base_addr = '0;
        repeat (3) @(negedge clock);
        check("reset ctrl outs", {mem_req, con_wren, llt_wren, busy, done, error}, 6'b0);
        check("reset data outs", |{mem_addr, llt_addr, llt_data}, 1'b0);
        reset = 1'b0;

        for (int i = 0; i < 8; i++) begin
            run_load($sformatf("vec%0d", i), vecs[i].base, vecs[i].cw, vecs[i].mw,
                     vecs[i].poke, vecs[i].nwr, vecs[i].lat, vecs[i].err);
            if (vecs[i].cw == 32'd6) begin
                check("table1 entry0 fetched from B+8",
                      (fetch_log.size() > 6) ? fetch_log[6] : '0, vecs[i].base + 24'd8);
            end
        end

        // Reset during the REQ of entry {2,1}, with N=5 clamped to 4.
        cur_base  = 24'h002000;
        cur_count = 32'd5;
        max_wait  = 2;
        hold_addr = 24'h002000 + 24'd2 + 24'd10 + 24'd1;
        hold_en   = 1'b1;
        wr_log.delete();
        fetch_log.delete();
        @(negedge clock);
        start     = 1'b1;
        base_addr = cur_base;
        @(negedge clock);
        start = 1'b0;
        k = 0;
        while (!(mem_req && (mem_addr == hold_addr)) && (k < 500)) begin
            @(negedge clock);
            k++;
        end
        check("rst: reached REQ {2,1}", mem_req && (mem_addr == hold_addr), 1'b1);
        check("rst: error set before reset", error, 1'b1);
        check("rst: writes before reset", wr_log.size(), 10);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("rst: ctrl outs after reset", {mem_req, con_wren, llt_wren, busy, done, error}, 6'b0);
        check("rst: data outs after reset", |{mem_addr, llt_addr, llt_data}, 1'b0);
        hold_en   = 1'b0;
        force_ack = 1'b1;
        repeat (2) @(negedge clock);
        force_ack = 1'b0;
        repeat (4) @(negedge clock);
        check("rst: late ack no strobe", wr_log.size(), 10);
        check("rst: idle after late ack", {busy, mem_req, done}, 3'b000);
        run_load("reload", 24'h002000, 32'd5, 2, -1, 17, 37, 1);

        // Randomized loads against the reference model.
        for (int r = 0; r < 24; r++) begin
            logic [31:0] cw;
            cw = {16'($urandom), 16'($urandom_range(0, 6))};
            if ((r % 6) == 5) cw[15:0] = 16'($urandom);
            mem_seed = $urandom;
            run_load($sformatf("rnd%0d", r), AW'($urandom), cw, int'($urandom_range(0, 5)),
                     ((r % 4) == 0) ? int'($urandom_range(0, 15)) : -1, -1, -1, -1);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/lease_table_loader.md
Name: lease_table_loader

Overview:
- Upstream configuration stage for the fully-associative lease cache policy controller.
- Fetches a lease-table image from word-addressed memory through a single-outstanding req/ack port.
- Replays the image as the controller's configuration writes (con_wren/llt_wren/llt_addr/llt_data) so the lookup table and default lease are loaded by hardware, not by core stores.
- busy_o is high for the whole load; cache traffic is gated by the cache controller while it is high.

Parameters:
- LLT_ENTRIES, 128, entries per lease table; power of two ≥ 2.
- BW_ENTRIES, CLOG2(LLT_ENTRIES), entry index width.
- BW_MEM_ADDR, 24, memory word-address width.

Ports:
- clock_i  in  1  system clock, all logic on rising edge
- reset_i  in  1  synchronous, active-high reset
- start_i  in  1  pulse: begin load; ignored while busy_o
- base_addr_i  in  BW_MEM_ADDR  image word address, sampled on accepted start_i
- mem_req_o  out  1  read request, held until mem_ack_i
- mem_addr_o  out  BW_MEM_ADDR  read word address, stable while mem_req_o
- mem_ack_i  in  1  read complete; mem_data_i valid this cycle only
- mem_data_i  in  32  read data
- con_wren_o  out  1  one-cycle config-register write strobe
- llt_wren_o  out  1  one-cycle lease-table write strobe
- llt_addr_o  out  BW_ENTRIES+2  {table[1:0], entry}; 0 for config writes
- llt_data_o  out  32  write data
- busy_o  out  1  load in progress
- done_o  out  1  one-cycle pulse at load completion
- error_o  out  1  sticky: image count exceeded LLT_ENTRIES; cleared on accepted start_i

Behaviour:
- Reset: every output 0; FSM in IDLE; all counters 0. Reset in any state aborts with no further strobes; a request already in flight is dropped, and any late mem_ack_i is ignored in IDLE.
- Image layout, relative to base B:
  - B+0: default lease.
  - B+1: count N (bits [15:0]; bits [31:16] ignored).
  - B+2+t*N+i: table t, entry i. t=0 reference addr, t=1 lease0, t=2 lease1, t=3 lease0 probability.
- States:
  - IDLE: on start_i, latch B, clear error_o, set busy_o, go REQ with word=HDR0.
  - REQ: mem_req_o=1, mem_addr_o=current address. On mem_ack_i, register data and go WRITE; mem_req_o drops the cycle after ack.
  - WRITE: issue exactly one action this cycle, then advance:
    - HDR0: con_wren_o=1, llt_addr_o=0, llt_data_o=data → REQ with word=HDR1.
    - HDR1: no strobe; latch N_img=data[15:0] and N_eff=min(N_img, LLT_ENTRIES); error_o=1 if N_img>LLT_ENTRIES. N_eff=0 → FINISH, else REQ with t=0, i=0.
    - Entry: llt_wren_o=1, llt_addr_o={t,i}, llt_data_o=data. If i=N_eff-1: table base += N_img, i=0, t+1; after t=3 → FINISH. Otherwise i+1 → REQ.
  - FINISH: done_o=1, busy_o=0, → IDLE.
- Addressing: entry address = table_base + i, with table_base starting at B+2. Clamped entries i≥N_eff are never fetched but are still skipped via the N_img stride. Memory addresses wrap modulo 2^BW_MEM_ADDR.
- Timing: minimum 2 cycles per word (REQ with same-cycle ack, then WRITE). Strobes never overlap, and no strobe occurs while mem_req_o is high.
- Full load of N≤LLT_ENTRIES with zero-wait memory: 2*(2+4N)+1 cycles from the cycle after start_i to done_o.
- start_i while busy: ignored, no effect on base or error_o. start_i in the same cycle as done_o: ignored.

Decomposition:
- Shared lease package: table index constants (TBL_ADDR=0, TBL_LEASE0=1, TBL_LEASE1=2, TBL_PROB=3), header offsets (HDR_DEFAULT=0, HDR_COUNT=1), and FSM state encoding.
- Single module; no sub-module is warranted.

Test Plan:
- B=0x100, N=2, zero-wait memory → con_wren with data M[0x100]; llt writes at {0,0},{0,1},{1,0}…{3,1} from M[0x102..0x109] in order; done_o exactly 21 cycles after start; error_o=0.
- N=0 → one con_wren, no llt_wren, done_o 5 cycles after start.
- LLT_ENTRIES=4, N=6 → 16 llt_wren; table-1 entry 0 fetched from B+8; error_o=1 until the next start.
- Random 0–5 ack wait states → mem_addr_o stable while mem_req_o high; the write sequence is identical to the zero-wait case.
- start_i pulsed mid-load with a different base → ignored; original sequence completes unchanged.
- reset_i asserted during REQ of entry {2,1} → all outputs 0 next cycle; late ack produces no strobe; a fresh start reloads completely.
